// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and default width for the EX-stage mult/div unit.
// The decoder and the hazard unit import the same op constants.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP   = 3'd0;
    localparam op_t OP_MULT  = 3'd1;
    localparam op_t OP_MULTU = 3'd2;
    localparam op_t OP_DIV   = 3'd3;
    localparam op_t OP_DIVU  = 3'd4;
    localparam op_t OP_MTHI  = 3'd5;
    localparam op_t OP_MTLO  = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage <-> mult/div unit bundle, plus architectural HI/LO and FSM state for debug.
// Handshake: start is the valid; an op is taken on a rising edge where start=1 and busy=0.
// While busy, stall=1 tells the hazard unit to hold start/op/a/b (and any mf_req) stable.
interface ex_muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) ();

    logic             start;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mf_req;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, a, b, mf_req,
        input  busy, stall, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, a, b, mf_req,
        output busy, stall, hi, lo, dbg_state
    );

endinterface

// File: rtl/muldiv_signfix.sv
// Turns the raw magnitude result in the accumulator into signed HI/LO values,
// including the divide-by-zero result.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic               is_div_i,
    input  logic               neg_res_i,
    input  logic               neg_rem_i,
    input  logic               div_zero_i,
    input  logic [WIDTH-1:0]   a_raw_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        prod = neg_res_i ? -acc_i : acc_i;
        quo  = neg_res_i ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
        rem  = neg_rem_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
        hi_o = prod[2*WIDTH-1:WIDTH];
        lo_o = prod[WIDTH-1:0];
        // Divide by zero hands back the untouched dividend rather than a corrected remainder.
        if (div_zero_i) begin
            hi_o = a_raw_i;
            lo_o = '1;
        end else if (is_div_i) begin
            hi_o = rem;
            lo_o = quo;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one result bit per cycle,
// 33 cycles from accept to HI/LO write, with stall to the hazard unit while busy.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic         clk,
    input  logic         clr_n,
    ex_muldiv_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;

    logic               is_signed, neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum, rem_sh, rem_diff;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign neg_a     = is_signed & bus.a[WIDTH-1];
    assign neg_b     = is_signed & bus.b[WIDTH-1];
    assign mag_a     = neg_a ? -bus.a : bus.a;
    assign mag_b     = neg_b ? -bus.b : bus.b;

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, divisor_q};
    // Divide: remainder in the upper half, dividend bits shifting out of the lower half.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, divisor_q};

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .acc_i      (acc_q),
        .is_div_i   (is_div_q),
        .neg_res_i  (neg_res_q),
        .neg_rem_i  (neg_rem_q),
        .div_zero_i (div_zero_q),
        .a_raw_i    (a_raw_q),
        .hi_o       (fix_hi),
        .lo_o       (fix_lo)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        divisor_d  = divisor_q;
        a_raw_d    = a_raw_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d    = (bus.op == OP_DIV || bus.op == OP_DIVU) ? ST_DIV : ST_MUL;
                            is_div_d   = (bus.op == OP_DIV || bus.op == OP_DIVU);
                            div_zero_d = (bus.op == OP_DIV || bus.op == OP_DIVU) && (bus.b == '0);
                            cnt_d      = CW'(WIDTH - 1);
                            acc_d      = {{WIDTH{1'b0}}, mag_a};
                            divisor_d  = mag_b;
                            a_raw_d    = bus.a;
                            neg_res_d  = neg_a ^ neg_b;
                            neg_rem_d  = neg_a;
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                acc_d = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
            end
            ST_DIV: begin
                acc_d = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
            default: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = ST_IDLE;
            end
        endcase
        if (state_q == ST_MUL || state_q == ST_DIV) begin
            if (cnt_q == '0) state_d = ST_FIX;
            else             cnt_d   = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            divisor_q  <= '0;
            a_raw_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            divisor_q  <= divisor_d;
            a_raw_q    <= a_raw_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.stall     = bus.busy & (bus.start | bus.mf_req);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.dbg_state = state_q;

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It consumes forwarded rs/rt operands and the decoded mult/div op from the ID/EX latch and computes MULT, MULTU, DIV and DIVU in 33 cycles. Results land in the architectural HI/LO registers, which it owns. It raises a stall to the hazard unit whenever the pipeline needs HI/LO, or the unit itself, while a computation is in flight.

## Interface
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH
- clk  in  1  pipeline clock; all state changes on the rising edge
- clr_n  in  1  reset, asynchronous, active-low
- start  in  1  EX holds a valid muldiv-class op this cycle
- op  in  3  op code (package constants): NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- a  in  WIDTH  rs operand after forwarding
- b  in  WIDTH  rt operand after forwarding
- mf_req  in  1  EX holds MFHI or MFLO this cycle
- busy  out  1  computation in flight
- stall  out  1  to hazard unit; freezes PC, IF/ID and ID/EX and bubbles EX/MEM
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start with MULT/MULTU: latch operands and go to MUL.
  - start with DIV/DIVU: latch operands and go to DIV.
  - start with MTHI/MTLO: write a to HI/LO at this edge and stay in IDLE.
  - NOP or no start: hold.
- Signed ops: the unit works on magnitudes and latches the sign information.
  - Product is negated if sign(a) != sign(b).
  - Quotient is negated if sign(a) != sign(b); remainder takes the sign of a.
- MUL: shift-add, one bit per cycle, 2·WIDTH accumulator, counter WIDTH-1 down to 0, then FIX.
- DIV: restoring divide, one quotient bit per cycle, same counter, then FIX.
- FIX: apply sign correction and write HI/LO, then return to IDLE.
  - Multiply: HI = upper half, LO = lower half.
  - Divide: HI = remainder, LO = quotient.
- Divide by zero (b = 0), signed or unsigned: HI = a, LO = all ones. No trap.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- stall = busy & (start | mf_req). A start or mf_req arriving while busy is held upstream by the stall, not dropped, and is accepted on the first IDLE cycle.
- MFHI/MFLO read hi/lo directly; the EX result mux selects them.
- Reset (clr_n low), asynchronous, at any time including mid-operation: state = IDLE, hi = 0, lo = 0, busy = 0, stall = 0, counter = 0, accumulator = 0. The in-flight op is abandoned.

## Timing
- Start accepted at edge E0. Iterations occur at E1..E32; FIX writes at E33.
- busy is high from just after E0 until just after E33 (33 cycles).
- New hi/lo values are visible in the cycle after E33. An MFHI held by the stall reads them in that cycle.
- MTHI/MTLO: single edge; the value is visible the next cycle.
- A start in the same cycle that FIX completes: busy is still high, so it stalls one cycle and is accepted at the next edge.
- busy and stall are registered-state-derived; stall is combinational in start/mf_req. There is no path from a or b to stall.

## Structure
- Shared package muldiv_pkg holds:
  - op code constants: NOP 0, MULT 1, MULTU 2, DIV 3, DIVU 4, MTHI 5, MTLO 6
  - state encoding
  - WIDTH default
- The hazard unit and the decoder import the same op constants.
- One sub-module is natural: muldiv_signfix, combinational. It takes the raw product/quotient/remainder plus the latched sign flags and produces the corrected HI/LO.
- FSM, counter and accumulator stay in ex_muldiv.

## Test plan
- Reset mid-operation: MULT 7×6, pull clr_n low at cycle 10 → immediately busy = 0, hi = lo = 0; a subsequent MULTU 3×5 → lo = 15, hi = 0 after 33 cycles.
- Signed multiply: MULT 0xFFFFFFFE × 3 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; busy high for exactly 33 cycles.
- Signed divide: DIV −7 / 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1). DIVU 7 / 2 → lo = 3, hi = 1.
- Corner divides: DIVU 5 / 0 → hi = 5, lo = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Hazard: MFHI with mf_req asserted at cycle 5 of a MULT → stall high until busy drops; hi valid in the release cycle.
- Back-to-back: a second MULT presented at cycle 2 of the first → stalls until busy drops, then completes 34 cycles later with its own correct result.
- MTLO 0x1234 in IDLE → lo = 0x1234 next cycle, busy stays 0, stall stays 0.
